// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline boundary registers: default field widths
// and the occupancy state encoding used by the skid stage.
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CTRL_W = 4;
    localparam int PIPE_DST_W  = 5;

    // Encoding doubles as the held-beat count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// Two-entry pipeline boundary register (output register plus skid register)
// with fully registered ready/valid handshakes and a flush that kills all beats.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DST_W  = PIPE_DST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [DST_W-1:0]  dst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic              flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [DST_W-1:0]  dst_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        count_o
);

    skid_state_t state, next_state;

    logic              valid_q, ready_q;
    logic [DATA_W-1:0] out_data, skid_data;
    logic [DST_W-1:0]  out_dst, skid_dst;
    logic [CTRL_W-1:0] out_ctrl, skid_ctrl;

    logic accept, drain;
    logic load_out_in, load_out_skid, load_skid;

    assign accept = valid_i && ready_q;
    assign drain  = valid_q && ready_i;

    always_comb begin
        next_state    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush_i) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        next_state  = ST_ONE;
                        load_out_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        load_out_in = 1'b1;
                    end else if (accept) begin
                        next_state = ST_FULL;
                        load_skid  = 1'b1;
                    end else if (drain) begin
                        next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        next_state    = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: next_state = ST_EMPTY;
            endcase
        end
    end

    // Handshake flags are flopped from the next state so neither depends
    // combinationally on the opposite side's handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            out_data  <= '0;
            out_dst   <= '0;
            out_ctrl  <= '0;
            skid_data <= '0;
            skid_dst  <= '0;
            skid_ctrl <= '0;
        end else begin
            state   <= next_state;
            valid_q <= (next_state != ST_EMPTY);
            ready_q <= (next_state != ST_FULL);
            if (load_out_in) begin
                out_data <= data_i;
                out_dst  <= dst_i;
                out_ctrl <= ctrl_i;
            end else if (load_out_skid) begin
                out_data <= skid_data;
                out_dst  <= skid_dst;
                out_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= data_i;
                skid_dst  <= dst_i;
                skid_ctrl <= ctrl_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign ready_o = ready_q;
    assign data_o  = out_data;
    assign dst_o   = out_dst;
    assign ctrl_o  = valid_q ? out_ctrl : '0;
    assign count_o = state;

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning datapath payload width (ALU result, store data, ...).
REQ-002 The block SHALL have parameter CTRL_W, default 4, meaning downstream-stage control bits (MemToReg, RegWrite, MemWrite, MemRead, ...).
REQ-003 The block SHALL have parameter DST_W, default 5, meaning destination register index width.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset; the ports are named clk and rst.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  asynchronous active-high reset.
REQ-007 Port valid_i  input  1  upstream beat valid.
REQ-008 Port ready_o  output  1  stage can accept a beat this cycle.
REQ-009 Port data_i  input  DATA_W  upstream payload.
REQ-010 Port dst_i  input  DST_W  upstream destination index.
REQ-011 Port ctrl_i  input  CTRL_W  upstream control bits.
REQ-012 Port flush_i  input  1  kill all held and incoming beats.
REQ-013 Port valid_o  output  1  downstream beat valid.
REQ-014 Port ready_i  input  1  downstream accepts beat.
REQ-015 Port data_o  output  DATA_W  held payload.
REQ-016 Port dst_o  output  DST_W  held destination index.
REQ-017 Port ctrl_o  output  CTRL_W  held control bits, gated by valid_o.
REQ-018 Port count_o  output  2  number of held beats (0..2).

Function
REQ-019 Storage SHALL be two entries: an output register (OUT) driving data_o/dst_o, and a skid register (SKID).
REQ-020 The state SHALL be one of EMPTY (0 beats), ONE (OUT valid), or FULL (OUT and SKID valid); count_o SHALL equal 0/1/2 accordingly.
REQ-021 An accept SHALL occur when valid_i && ready_o; a drain SHALL occur when valid_o && ready_i.
REQ-022 ready_o SHALL be a registered signal equal to (state != FULL), with no combinational path from ready_i.
REQ-023 EMPTY SHALL go to ONE on accept, loading OUT at that edge, giving one-cycle latency.
REQ-024 ONE SHALL behave as follows: accept+drain loads OUT and stays ONE; accept only loads SKID and goes FULL; drain only goes EMPTY; neither holds.
REQ-025 FULL SHALL behave as follows: drain moves SKID to OUT and goes ONE; no accept is possible because ready_o=0.
REQ-026 OUT and SKID SHALL keep their contents while held; no beat SHALL be lost or duplicated, and order SHALL be preserved.
REQ-027 flush_i=1 at an edge SHALL force state EMPTY and discard any beat accepted at that edge; flush SHALL have priority over accept and drain.
REQ-028 ctrl_o SHALL be all-zero whenever valid_o=0, which makes a bubble, and SHALL equal the held ctrl when valid_o=1.
REQ-029 data_o and dst_o SHALL retain their last loaded value when valid_o=0.
REQ-030 valid_o SHALL equal (state != EMPTY) and SHALL be registered.
REQ-031 The block SHALL perform no arithmetic; all fields SHALL pass through width-exact.

Reset
REQ-032 Asserting rst SHALL immediately force state EMPTY, valid_o=0, ready_o=1, count_o=0, ctrl_o=0, data_o=0, dst_o=0, and SKID=0.
REQ-033 While rst=1, the block SHALL accept no beats; the first accept SHALL be possible on the first rising edge after rst deasserts.
REQ-034 Reset asserted mid-operation, including in state FULL, SHALL discard all held beats without emitting them.

Structure
REQ-035 The state encoding (EMPTY/ONE/FULL) and the default widths SHALL live in the shared package pipe_pkg.
REQ-036 The block SHALL be a single module with no sub-module, and SHALL be instantiable per pipeline boundary (ID/EX, EX/MEM, MEM/WB) by parameter override.

Verification
REQ-037 The bench SHALL check reset: rst pulse while FULL -> valid_o=0, ready_o=1, count_o=0, ctrl_o=0 immediately.
REQ-038 The bench SHALL check streaming: ready_i=1, beats data 0x11,0x22,0x33 on consecutive cycles -> valid_o beats 0x11,0x22,0x33 one cycle later each, count_o=1 throughout.
REQ-039 The bench SHALL check backpressure: ready_i=0, send 0xA1,0xA2 -> count_o=2 and ready_o=0 the cycle after; raise ready_i -> 0xA1 then 0xA2 out in order with no loss.
REQ-040 The bench SHALL check flush: FULL with ctrl 0xF, flush_i=1 with valid_i=1 data 0xBB -> next cycle valid_o=0, ctrl_o=0, count_o=0, and 0xBB never appears.
REQ-041 The bench SHALL check simultaneous events: ONE holding 0x05 with accept 0x06 and drain in the same cycle -> 0x05 consumed, OUT=0x06, count_o stays 1.
REQ-042 The bench SHALL check the bubble: valid_i=0 for 3 cycles with ready_i=1 -> ctrl_o=0 and data_o holding the last value during all 3.
